// File: rtl/psram_bridge_pkg.sv
// psram_bridge_pkg: shared types and helpers for psram_bus_bridge.
//   state_e          bridge FSM states
//   XFER_RD/XFER_WR  encoding of xfer_rdwr_o
//   word_addr_bits   number of word-address bits above the byte lane bits
package psram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic XFER_RD = 1'b1;
  localparam logic XFER_WR = 1'b0;

  function automatic int unsigned word_addr_bits(input int unsigned size,
                                                 input int unsigned dw);
    return $clog2(size) - $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/psram_rdbuf.sv
// psram_rdbuf: one-entry read buffer (tag = aligned word address, data, valid).
// Only compiled when PSRAM_BRIDGE_RDBUF_EN is defined.
// Ports:
//   clk_i, rst_n_i   clock, synchronous active-low reset (clears valid)
//   lookup_addr_i    aligned address of the incoming user read
//   hit_o/hit_data_o buffer holds lookup_addr_i / its data
//   fill_i           store fill_addr_i/fill_data_i (read miss completed)
//   inval_all_i      drop the entry (config transfer)
//   inval_wr_i       drop the entry if it matches inval_addr_i (user write)
`ifdef PSRAM_BRIDGE_RDBUF_EN
module psram_rdbuf #(
  parameter int unsigned AW = 26,
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [AW-1:0] lookup_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] hit_data_o,
  input  logic          fill_i,
  input  logic [AW-1:0] fill_addr_i,
  input  logic [DW-1:0] fill_data_i,
  input  logic          inval_all_i,
  input  logic          inval_wr_i,
  input  logic [AW-1:0] inval_addr_i
);

  logic          valid_q, valid_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;

  assign hit_o      = valid_q && (tag_q == lookup_addr_i);
  assign hit_data_o = data_q;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inval_all_i || (inval_wr_i && (tag_q == inval_addr_i))) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_addr_i;
      data_d  = fill_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

endmodule
`endif

// File: rtl/psram_bus_bridge.sv
// psram_bus_bridge: turns AXI user read/write requests and APB config requests
// into single psram_core transfers, one outstanding at a time.
// Ports:
//   clk_i, rst_n_i            clock, synchronous active-low reset
//   usr_*                     user request in, accept/complete pulses and read data out
//   cfg_req_i/cfg_rdwr_i      one-cycle config request; cfg_busy_o/cfg_done_o/cfg_sel_o status
//   xfer_*/bus_*              psram_core transfer handshake, address, data, mask
// Optional: PSRAM_BRIDGE_RDBUF_EN adds a one-entry read buffer (psram_rdbuf).
module psram_bus_bridge
  import psram_bridge_pkg::*;
#(
  parameter int unsigned USR_ADDR_SIZE = 64 * 1024 * 1024,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                usr_en_i,
  input  logic                                usr_wen_i,
  input  logic [31:0]                         usr_addr_i,
  input  logic [DATA_WIDTH/8-1:0]             usr_bm_i,
  input  logic [DATA_WIDTH-1:0]               usr_dat_i,
  output logic [DATA_WIDTH-1:0]               usr_dat_o,
  output logic                                usr_awready_o,
  output logic                                usr_wready_o,
  output logic                                usr_arready_o,
  output logic                                usr_bvalid_o,
  output logic                                usr_rvalid_o,
  input  logic                                cfg_req_i,
  input  logic                                cfg_rdwr_i,
  output logic                                cfg_busy_o,
  output logic                                cfg_done_o,
  output logic                                cfg_sel_o,
  output logic                                xfer_valid_o,
  output logic                                xfer_rdwr_o,
  input  logic                                xfer_ready_i,
  output logic [$clog2(USR_ADDR_SIZE)-1:0]    bus_addr_o,
  output logic [DATA_WIDTH-1:0]               bus_wr_data_o,
  output logic [DATA_WIDTH/8-1:0]             bus_wr_mask_o,
  input  logic [DATA_WIDTH-1:0]               bus_rd_data_i
);

  localparam int unsigned BA  = $clog2(USR_ADDR_SIZE);
  localparam int unsigned BW  = DATA_WIDTH / 8;
  localparam int unsigned LSB = BA - word_addr_bits(USR_ADDR_SIZE, DATA_WIDTH);
  localparam logic [BA-1:0] ALIGN_MASK = {BA{1'b1}} << LSB;

  state_e                state_q, state_d;
  logic                  pend_q, pend_d, pend_rd_q, pend_rd_d;
  logic                  sel_q, sel_d, rdwr_q, rdwr_d, nop_q, nop_d;
  logic [BA-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic [BW-1:0]         bm_q, bm_d;
  logic                  awr_q, awr_d, arr_q, arr_d;
  logic                  bval_q, bval_d, rval_q, rval_d, done_q, done_d;

  logic [BA-1:0]         usr_word_addr;
  logic                  cfg_take, cfg_go;
  logic                  rb_hit;
  logic [DATA_WIDTH-1:0] rb_data;
  logic                  unused_addr_hi;

  // Upper address bits beyond the device size alias (modulo wrap).
  assign usr_word_addr  = usr_addr_i[BA-1:0] & ALIGN_MASK;
  assign unused_addr_hi = ^usr_addr_i[31:BA];

  assign cfg_busy_o = pend_q | ((state_q != IDLE) & sel_q);
  // A request arriving while one is pending or in flight is dropped.
  assign cfg_take   = cfg_req_i & ~cfg_busy_o;
  // Same-cycle cfg_req_i already beats a simultaneous user request.
  assign cfg_go     = pend_q | cfg_take;

`ifdef PSRAM_BRIDGE_RDBUF_EN
  psram_rdbuf #(
    .AW (BA),
    .DW (DATA_WIDTH)
  ) u_rdbuf (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .lookup_addr_i (usr_word_addr),
    .hit_o         (rb_hit),
    .hit_data_o    (rb_data),
    .fill_i        ((state_q == ISSUE) & xfer_ready_i & ~sel_q & (rdwr_q == XFER_RD)),
    .fill_addr_i   (addr_q),
    .fill_data_i   (bus_rd_data_i),
    .inval_all_i   ((state_q == IDLE) & cfg_go),
    .inval_wr_i    ((state_q == IDLE) & ~cfg_go & usr_en_i & usr_wen_i),
    .inval_addr_i  (usr_word_addr)
  );
`else
  assign rb_hit  = 1'b0;
  assign rb_data = '0;
`endif

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    pend_rd_d = pend_rd_q;
    sel_d     = sel_q;
    rdwr_d    = rdwr_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    bm_d      = bm_q;
    rdat_d    = rdat_q;
    nop_d     = 1'b0;
    awr_d     = 1'b0;
    arr_d     = 1'b0;
    bval_d    = 1'b0;
    rval_d    = 1'b0;
    done_d    = 1'b0;
    if (cfg_take) begin
      pend_d    = 1'b1;
      pend_rd_d = cfg_rdwr_i;
    end
    unique case (state_q)
      IDLE: begin
        if (cfg_go) begin
          state_d = ISSUE;
          pend_d  = 1'b0;
          sel_d   = 1'b1;
          rdwr_d  = pend_q ? pend_rd_q : cfg_rdwr_i;
          addr_d  = '0;
          wdat_d  = '0;
          bm_d    = '1;
        end else if (usr_en_i) begin
          sel_d  = 1'b0;
          rdwr_d = usr_wen_i ? XFER_WR : XFER_RD;
          addr_d = usr_word_addr;
          wdat_d = usr_dat_i;
          bm_d   = usr_bm_i;
          if (usr_wen_i) begin
            awr_d = 1'b1;
            // Empty-mask write: no core access, but one spare RESP cycle
            // keeps bvalid at the same distance as the fastest real write.
            if (usr_bm_i == '0) begin
              state_d = RESP;
              nop_d   = 1'b1;
            end else begin
              state_d = ISSUE;
            end
          end else begin
            arr_d = 1'b1;
            if (rb_hit) begin
              state_d = RESP;
              rval_d  = 1'b1;
              rdat_d  = rb_data;
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        if (xfer_ready_i) begin
          state_d = RESP;
          if (sel_q) begin
            done_d = 1'b1;
          end else if (rdwr_q == XFER_RD) begin
            rval_d = 1'b1;
            rdat_d = bus_rd_data_i;
          end else begin
            bval_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (nop_q) begin
          bval_d = 1'b1;
        end else begin
          state_d = IDLE;
          sel_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      pend_rd_q <= 1'b0;
      sel_q     <= 1'b0;
      rdwr_q    <= 1'b0;
      nop_q     <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      bm_q      <= '0;
      rdat_q    <= '0;
      awr_q     <= 1'b0;
      arr_q     <= 1'b0;
      bval_q    <= 1'b0;
      rval_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      pend_rd_q <= pend_rd_d;
      sel_q     <= sel_d;
      rdwr_q    <= rdwr_d;
      nop_q     <= nop_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      bm_q      <= bm_d;
      rdat_q    <= rdat_d;
      awr_q     <= awr_d;
      arr_q     <= arr_d;
      bval_q    <= bval_d;
      rval_q    <= rval_d;
      done_q    <= done_d;
    end
  end

  assign usr_dat_o     = rdat_q;
  assign usr_awready_o = awr_q;
  assign usr_wready_o  = awr_q;
  assign usr_arready_o = arr_q;
  assign usr_bvalid_o  = bval_q;
  assign usr_rvalid_o  = rval_q;
  assign cfg_done_o    = done_q;
  assign cfg_sel_o     = sel_q;
  assign xfer_valid_o  = (state_q == ISSUE);
  assign xfer_rdwr_o   = rdwr_q;
  assign bus_addr_o    = addr_q;
  assign bus_wr_data_o = wdat_q;
  assign bus_wr_mask_o = bm_q;

endmodule
